// File: rtl/collision_fsm_pkg.sv
// rtl/collision_fsm_pkg.sv - shared state encoding and geometry defaults for collision_fsm
package collision_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int BIRD_X_DEF   = 400;
  localparam int BIRD_W_DEF   = 40;
  localparam int BIRD_H_DEF   = 40;
  localparam int PIPE_W_DEF   = 80;
  localparam int GAP_HALF_DEF = 100;
  localparam int SCREEN_H_DEF = 900;

endpackage

// File: rtl/pipe_hit_check.sv
// rtl/pipe_hit_check.sv - combinational bird-versus-one-pipe overlap test
module pipe_hit_check
  import collision_fsm_pkg::*;
#(
  parameter int BIRD_X   = BIRD_X_DEF,
  parameter int BIRD_W   = BIRD_W_DEF,
  parameter int BIRD_H   = BIRD_H_DEF,
  parameter int PIPE_W   = PIPE_W_DEF,
  parameter int GAP_HALF = GAP_HALF_DEF
) (
  input  logic [11:0] bpos_y,
  input  logic [11:0] px,
  input  logic [11:0] py,
  output logic        hit
);

  localparam logic [12:0] BX  = 13'(BIRD_X);
  localparam logic [12:0] BXW = 13'(BIRD_X + BIRD_W);
  localparam logic [12:0] BH  = 13'(BIRD_H);
  localparam logic [12:0] PW  = 13'(PIPE_W);
  localparam logic [12:0] GH  = 13'(GAP_HALF);

  logic [12:0] by13, px13, py13, gap_top;
  logic        overlap;

  // 13-bit arithmetic keeps every sum from wrapping; gap top clamps at 0
  always_comb begin
    by13    = {1'b0, bpos_y};
    px13    = {1'b0, px};
    py13    = {1'b0, py};
    gap_top = (py13 < GH) ? 13'd0 : (py13 - GH);
    overlap = (BXW > px13) && (BX < (px13 + PW));
    hit     = overlap && ((by13 < gap_top) || ((by13 + BH) > (py13 + GH)));
  end

endmodule

// File: rtl/collision_fsm.sv
// rtl/collision_fsm.sv - game state FSM with sequential per-frame collision scan
module collision_fsm
  import collision_fsm_pkg::*;
#(
  parameter int BIRD_X   = BIRD_X_DEF,
  parameter int BIRD_W   = BIRD_W_DEF,
  parameter int BIRD_H   = BIRD_H_DEF,
  parameter int PIPE_W   = PIPE_W_DEF,
  parameter int GAP_HALF = GAP_HALF_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_btn,
  input  logic [11:0] bpos_y,
  input  logic [11:0] pippos_x1,
  input  logic [11:0] pippos_x2,
  input  logic [11:0] pippos_x3,
  input  logic [11:0] pippos_y1,
  input  logic [11:0] pippos_y2,
  input  logic [11:0] pippos_y3,
  input  logic [3:0]  score,
  output logic        is_start,
  output logic        is_over,
  output logic [1:0]  hit_src,
  output logic [3:0]  best_score,
  output logic        busy
);

  localparam logic [12:0] BH = 13'(BIRD_H);
  localparam logic [12:0] SH = 13'(SCREEN_H);

  state_t      state, state_d;
  logic [1:0]  idx;
  logic [11:0] snap_y;
  logic [11:0] snap_px1, snap_px2, snap_px3;
  logic [11:0] snap_py1, snap_py2, snap_py3;
  logic [11:0] sel_px, sel_py;
  logic        pipe_hit, bound_hit, cur_hit;
  logic        start_en, snap_en, idx_inc, hit_en, done_en, clear_en;

  always_comb begin
    sel_px = snap_px1;
    sel_py = snap_py1;
    case (idx)
      2'd2:    begin sel_px = snap_px2; sel_py = snap_py2; end
      2'd3:    begin sel_px = snap_px3; sel_py = snap_py3; end
      default: begin sel_px = snap_px1; sel_py = snap_py1; end
    endcase
  end

  pipe_hit_check #(
    .BIRD_X  (BIRD_X),
    .BIRD_W  (BIRD_W),
    .BIRD_H  (BIRD_H),
    .PIPE_W  (PIPE_W),
    .GAP_HALF(GAP_HALF)
  ) u_pipe_hit_check (
    .bpos_y(snap_y),
    .px    (sel_px),
    .py    (sel_py),
    .hit   (pipe_hit)
  );

  assign bound_hit = (({1'b0, snap_y} + BH) >= SH) || (snap_y == 12'd0);
  assign cur_hit   = (idx == 2'd0) ? bound_hit : pipe_hit;

  always_comb begin
    state_d  = state;
    start_en = 1'b0;
    snap_en  = 1'b0;
    idx_inc  = 1'b0;
    hit_en   = 1'b0;
    done_en  = 1'b0;
    clear_en = 1'b0;
    case (state)
      ST_IDLE: if (start_btn) begin state_d = ST_RUN; start_en = 1'b1; end
      ST_RUN:  if (tick) begin state_d = ST_SCAN; snap_en = 1'b1; end
      ST_SCAN: begin
        if (cur_hit) begin
          state_d = ST_OVER;
          hit_en  = 1'b1;
        end else if (idx == 2'd3) begin
          state_d = ST_RUN;
          done_en = 1'b1;
        end else begin
          idx_inc = 1'b1;
        end
      end
      ST_OVER: if (start_btn) begin state_d = ST_IDLE; clear_en = 1'b1; end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_start   <= 1'b0;
      is_over    <= 1'b0;
      hit_src    <= 2'd0;
      best_score <= 4'd0;
      busy       <= 1'b0;
      idx        <= 2'd0;
      snap_y     <= 12'd0;
      snap_px1   <= 12'd0;
      snap_px2   <= 12'd0;
      snap_px3   <= 12'd0;
      snap_py1   <= 12'd0;
      snap_py2   <= 12'd0;
      snap_py3   <= 12'd0;
    end else begin
      state <= state_d;
      if (start_en) is_start <= 1'b1;
      if (snap_en) begin
        snap_y   <= bpos_y;
        snap_px1 <= pippos_x1;
        snap_px2 <= pippos_x2;
        snap_px3 <= pippos_x3;
        snap_py1 <= pippos_y1;
        snap_py2 <= pippos_y2;
        snap_py3 <= pippos_y3;
        idx      <= 2'd0;
        busy     <= 1'b1;
      end
      if (idx_inc) idx <= idx + 2'd1;
      if (hit_en) begin
        is_over <= 1'b1;
        hit_src <= idx;
        busy    <= 1'b0;
        if (score > best_score) best_score <= score;
      end
      if (done_en) busy <= 1'b0;
      if (clear_en) begin
        is_start <= 1'b0;
        is_over  <= 1'b0;
        hit_src  <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_collision_fsm.sv
// tb/tb_collision_fsm.sv - vector table and scoreboard bench for collision_fsm
module tb_collision_fsm;

  logic        clk = 1'b0;
  logic        rst, tick, start_btn;
  logic [11:0] bpos_y, pippos_x1, pippos_x2, pippos_x3, pippos_y1, pippos_y2, pippos_y3;
  logic [3:0]  score;
  logic        is_start, is_over, busy;
  logic [1:0]  hit_src;
  logic [3:0]  best_score;

  always #5 clk = ~clk;

  collision_fsm dut (
    .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn), .bpos_y(bpos_y),
    .pippos_x1(pippos_x1), .pippos_x2(pippos_x2), .pippos_x3(pippos_x3),
    .pippos_y1(pippos_y1), .pippos_y2(pippos_y2), .pippos_y3(pippos_y3),
    .score(score), .is_start(is_start), .is_over(is_over), .hit_src(hit_src),
    .best_score(best_score), .busy(busy)
  );

  typedef struct {
    logic [11:0] by;
    logic [11:0] px1, py1, px2, py2, px3, py3;
    logic [3:0]  sc;
    logic        hit;
    logic [1:0]  src;
    int          lat;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [1:0] src;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[12];
  int         total = 0;
  int         bad = 0;
  logic [3:0] best_m = 4'd0;

  function automatic vec_t mk(input int by, input int px1, input int py1, input int px2,
                              input int py2, input int px3, input int py3, input int sc,
                              input bit hit, input int src, input int lat);
    vec_t v;
    v.by = 12'(by); v.px1 = 12'(px1); v.py1 = 12'(py1); v.px2 = 12'(px2);
    v.py2 = 12'(py2); v.px3 = 12'(px3); v.py3 = 12'(py3); v.sc = 4'(sc);
    v.hit = hit; v.src = 2'(src); v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic run_scan(input vec_t v, input bit tick_mid);
    exp_t e;
    int   n;
    bit   done;
    @(negedge clk);
    bpos_y = v.by; pippos_x1 = v.px1; pippos_y1 = v.py1; pippos_x2 = v.px2;
    pippos_y2 = v.py2; pippos_x3 = v.px3; pippos_y3 = v.py3; score = v.sc;
    tick = 1'b1;
    e.hit = v.hit; e.src = v.src; e.lat = v.lat;
    sb.push_back(e);
    @(negedge clk);
    tick = 1'b0;
    // live inputs move after the tick; the scan must use the snapshot
    bpos_y = 12'd0; pippos_x1 = 12'd400; pippos_y1 = 12'd0;
    chk("busy_after_tick", busy, 1);
    n = 0;
    done = 1'b0;
    while (!done && n < 8) begin
      tick = (tick_mid && n == 1);
      @(negedge clk);
      n++;
      if (is_over || !busy) done = 1'b1;
    end
    tick = 1'b0;
    e = sb.pop_front();
    chk("scan_done", done, 1);
    chk("latency", n, e.lat);
    chk("is_over", is_over, e.hit);
    chk("hit_src", hit_src, e.hit ? e.src : 2'd0);
    chk("busy_end", busy, 0);
    if (e.hit && v.sc > best_m) best_m = v.sc;
    chk("best_score", best_score, best_m);
    if (!e.hit) begin
      @(negedge clk);
      chk("run_idle_busy", busy, 0);
      chk("run_is_start", is_start, 1);
    end
  endtask

  task automatic restart();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("over_tick_ignored", is_over, 1);
    chk("over_busy", busy, 0);
    chk("over_is_start", is_start, 1);
    start_btn = 1'b1;
    @(negedge clk); start_btn = 1'b0;
    chk("idle_is_start", is_start, 0);
    chk("idle_is_over", is_over, 0);
    chk("idle_hit_src", hit_src, 0);
    chk("idle_best", best_score, best_m);
    start_btn = 1'b1;
    @(negedge clk); start_btn = 1'b0;
    chk("restart_is_start", is_start, 1);
  endtask

  initial begin
    vecs[0]  = mk(300,  420, 320, 1500, 450, 1500, 450, 1, 0, 0, 4);
    vecs[1]  = mk(100, 1500, 450,  400, 400, 1500, 450, 7, 1, 2, 3);
    vecs[2]  = mk(870,  400, 450, 1500, 450, 1500, 450, 5, 1, 0, 1);
    vecs[3]  = mk(0,    400,  50, 1500, 450, 1500, 450, 3, 1, 0, 1);
    vecs[4]  = mk(10,   400,  50, 1500, 450, 1500, 450, 2, 0, 0, 4);
    vecs[5]  = mk(600, 1500, 450, 1500, 450,  380, 400, 9, 1, 3, 4);
    vecs[6]  = mk(100,  440, 400,  320, 400, 1500, 450, 2, 0, 0, 4);
    vecs[7]  = mk(100,  439, 400, 1500, 450, 1500, 450, 4, 1, 1, 2);
    vecs[8]  = mk(860, 1500, 450, 1500, 450, 1500, 450, 8, 1, 0, 1);
    vecs[9]  = mk(859, 1500, 450, 1500, 450, 1500, 450, 2, 0, 0, 4);
    vecs[10] = mk(4095, 1500, 450, 1500, 450, 1500, 450, 6, 1, 0, 1);
    vecs[11] = mk(100,  400, 400, 1500, 450,  400, 400, 10, 1, 1, 2);

    rst = 1'b1; tick = 1'b0; start_btn = 1'b0; score = 4'd0;
    bpos_y = 12'd0; pippos_x1 = 12'd0; pippos_x2 = 12'd0; pippos_x3 = 12'd0;
    pippos_y1 = 12'd0; pippos_y2 = 12'd0; pippos_y3 = 12'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_is_start", is_start, 0);
    chk("rst_is_over", is_over, 0);
    chk("rst_hit_src", hit_src, 0);
    chk("rst_best", best_score, 0);
    chk("rst_busy", busy, 0);

    // start and tick together: tick dropped
    start_btn = 1'b1; tick = 1'b1;
    @(negedge clk); start_btn = 1'b0; tick = 1'b0;
    chk("start_is_start", is_start, 1);
    chk("start_tick_dropped", busy, 0);
    @(negedge clk);
    chk("start_no_over", is_over, 0);

    start_btn = 1'b1;
    @(negedge clk); start_btn = 1'b0;
    chk("run_ignores_start", is_start, 1);

    for (int i = 0; i < 12; i++) begin
      run_scan(vecs[i], i == 0);
      if (vecs[i].hit) restart();
    end

    // reset during the second scan cycle
    @(negedge clk);
    bpos_y = 12'd100; pippos_x1 = 12'd1500; pippos_x2 = 12'd400; pippos_y2 = 12'd400;
    pippos_x3 = 12'd1500; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    best_m = 4'd0;
    chk("mid_rst_is_start", is_start, 0);
    chk("mid_rst_is_over", is_over, 0);
    chk("mid_rst_hit_src", hit_src, 0);
    chk("mid_rst_best", best_score, best_m);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_stays_idle", is_over, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
